// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 16-bit memory between the fetch and load/store ports.
// Load/store has priority unless fetch has been denied STARVE_LIMIT times in a row.
module mem_port_arbiter #(
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_if_rd,
   input  logic [15:0] i_if_addr,
   output logic        o_if_wait,
   output logic [15:0] o_if_rddata,
   output logic        o_if_rdvalid,
   input  logic        i_ls_rd,
   input  logic        i_ls_wr,
   input  logic [15:0] i_ls_addr,
   input  logic [15:0] i_ls_wrdata,
   output logic        o_ls_wait,
   output logic [15:0] o_ls_rddata,
   output logic        o_ls_rdvalid,
   output logic [15:0] o_mem_addr,
   output logic        o_mem_rd,
   output logic        o_mem_wr,
   output logic [15:0] o_mem_wrdata,
   input  logic [15:0] i_mem_rddata,
   output logic [15:0] o_conflict_cnt,
   output logic [1:0]  o_last_grant
);

   typedef enum logic [1:0] {
      LAST_NONE = 2'd0,
      LAST_IF   = 2'd1,
      LAST_LS   = 2'd2
   } last_e;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic                  ifq;
   logic                  lsq;
   logic                  grant_if;
   logic                  grant_ls;

   logic [RD_LATENCY-1:0] pipe_vld_q;
   logic [RD_LATENCY-1:0] pipe_vld_d;
   logic [RD_LATENCY-1:0] pipe_port_q;
   logic [RD_LATENCY-1:0] pipe_port_d;
   logic [3:0]            starve_cnt_q;
   logic [3:0]            starve_cnt_d;
   logic [15:0]           conflict_cnt_q;
   logic [15:0]           conflict_cnt_d;
   last_e                 last_q;
   last_e                 last_d;

   // Arbitration; nothing is granted while reset is high.
   always_comb begin
      ifq      = i_if_rd;
      lsq      = i_ls_rd | i_ls_wr;
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (reset) begin
         grant_if = 1'b0;
         grant_ls = 1'b0;
      end else if (ifq && lsq) begin
         if (starve_cnt_q == STARVE_MAX) begin
            grant_if = 1'b1;
         end else begin
            grant_ls = 1'b1;
         end
      end else begin
         grant_if = ifq;
         grant_ls = lsq;
      end
   end

   // Waits and memory strobes; a load/store with both rd and wr is a write.
   always_comb begin
      o_if_wait    = ifq & ~grant_if;
      o_ls_wait    = lsq & ~grant_ls;
      o_mem_addr   = 16'h0000;
      o_mem_rd     = 1'b0;
      o_mem_wr     = 1'b0;
      o_mem_wrdata = 16'h0000;
      if (grant_if) begin
         o_mem_addr = i_if_addr;
         o_mem_rd   = 1'b1;
      end else if (grant_ls) begin
         o_mem_addr   = i_ls_addr;
         o_mem_wr     = i_ls_wr;
         o_mem_rd     = i_ls_rd & ~i_ls_wr;
         o_mem_wrdata = i_ls_wrdata;
      end else begin
         o_mem_rd = 1'b0;
      end
   end

   // Next-state for the response pipe, starvation, conflict and last-grant registers.
   always_comb begin
      pipe_vld_d     = {RD_LATENCY{1'b0}};
      pipe_port_d    = {RD_LATENCY{1'b0}};
      pipe_vld_d[0]  = o_mem_rd;
      pipe_port_d[0] = grant_ls;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_port_d[i] = pipe_port_q[i-1];
      end

      starve_cnt_d = 4'd0;
      if (ifq && grant_ls) begin
         if (starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
         end else begin
            starve_cnt_d = starve_cnt_q;
         end
      end else begin
         starve_cnt_d = 4'd0;
      end

      conflict_cnt_d = conflict_cnt_q;
      if (ifq && lsq && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end else begin
         conflict_cnt_d = conflict_cnt_q;
      end

      case ({grant_if, grant_ls})
         2'b10:   last_d = LAST_IF;
         2'b01:   last_d = LAST_LS;
         default: last_d = LAST_NONE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_vld_q     <= {RD_LATENCY{1'b0}};
         pipe_port_q    <= {RD_LATENCY{1'b0}};
         starve_cnt_q   <= 4'd0;
         conflict_cnt_q <= 16'd0;
         last_q         <= LAST_NONE;
      end else begin
         pipe_vld_q     <= pipe_vld_d;
         pipe_port_q    <= pipe_port_d;
         starve_cnt_q   <= starve_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
         last_q         <= last_d;
      end
   end

   // Response routing from the pipe tail; port bit 1 marks a load.
   always_comb begin
      o_if_rddata    = i_mem_rddata;
      o_ls_rddata    = i_mem_rddata;
      o_if_rdvalid   = pipe_vld_q[RD_LATENCY-1] & ~pipe_port_q[RD_LATENCY-1] & ~reset;
      o_ls_rdvalid   = pipe_vld_q[RD_LATENCY-1] &  pipe_port_q[RD_LATENCY-1] & ~reset;
      o_conflict_cnt = conflict_cnt_q;
      o_last_grant   = last_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter with a queue-based response scoreboard.
module tb_mem_port_arbiter;

   localparam int L   = 3;
   localparam int LIM = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_if_rd = 1'b0;
   logic [15:0] i_if_addr = 16'h0000;
   logic        o_if_wait;
   logic [15:0] o_if_rddata;
   logic        o_if_rdvalid;
   logic        i_ls_rd = 1'b0;
   logic        i_ls_wr = 1'b0;
   logic [15:0] i_ls_addr = 16'h0000;
   logic [15:0] i_ls_wrdata = 16'h0000;
   logic        o_ls_wait;
   logic [15:0] o_ls_rddata;
   logic        o_ls_rdvalid;
   logic [15:0] o_mem_addr;
   logic        o_mem_rd;
   logic        o_mem_wr;
   logic [15:0] o_mem_wrdata;
   logic [15:0] i_mem_rddata = 16'h0000;
   logic [15:0] o_conflict_cnt;
   logic [1:0]  o_last_grant;

   mem_port_arbiter #(.RD_LATENCY(L), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .i_if_rd(i_if_rd), .i_if_addr(i_if_addr), .o_if_wait(o_if_wait),
      .o_if_rddata(o_if_rddata), .o_if_rdvalid(o_if_rdvalid),
      .i_ls_rd(i_ls_rd), .i_ls_wr(i_ls_wr), .i_ls_addr(i_ls_addr),
      .i_ls_wrdata(i_ls_wrdata), .o_ls_wait(o_ls_wait),
      .o_ls_rddata(o_ls_rddata), .o_ls_rdvalid(o_ls_rdvalid),
      .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
      .o_mem_wrdata(o_mem_wrdata), .i_mem_rddata(i_mem_rddata),
      .o_conflict_cnt(o_conflict_cnt), .o_last_grant(o_last_grant)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int due;
      bit port;
   } rsp_t;
   rsp_t sb[$];

   int  n_err = 0;
   int  n_chk = 0;
   bit  mon_en = 1'b0;

   int  m_denied = 0;
   int  m_conf = 0;
   int  m_last = 0;

   function automatic logic [15:0] mem_word(input int c);
      return 16'(c * 40503) ^ 16'h5A5A;
   endfunction

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk16(name, {15'd0, act}, {15'd0, exp});
   endtask

   // One bus cycle: drive, check combinational response, advance the reference model.
   task automatic step(input bit r, input bit ir, input logic [15:0] ia, input bit lr,
                       input bit lw, input logic [15:0] la, input logic [15:0] wd);
      bit ifq, lsq, gi, gl;
      @(posedge clk);
      #1;
      reset = r; i_if_rd = ir; i_if_addr = ia; i_ls_rd = lr; i_ls_wr = lw;
      i_ls_addr = la; i_ls_wrdata = wd; i_mem_rddata = mem_word(cyc);
      @(negedge clk);
      ifq = ir;
      lsq = lr | lw;
      if (r) begin
         gi = 1'b0; gl = 1'b0;
      end else if (ifq && lsq) begin
         gi = (m_denied >= LIM);
         gl = !gi;
      end else begin
         gi = ifq; gl = lsq;
      end
      chk1("if_wait", o_if_wait, ifq & !gi);
      chk1("ls_wait", o_ls_wait, lsq & !gl);
      chk1("mem_rd", o_mem_rd, gi | (gl & lr & !lw));
      chk1("mem_wr", o_mem_wr, gl & lw);
      if (gi) chk16("mem_addr_if", o_mem_addr, ia);
      if (gl) chk16("mem_addr_ls", o_mem_addr, la);
      if (gl && lw) chk16("mem_wrdata", o_mem_wrdata, wd);
      chk16("conflict_cnt", o_conflict_cnt, 16'(m_conf));
      chk16("last_grant", {14'd0, o_last_grant}, 16'(m_last));

      if (r) begin
         sb.delete();
         m_denied = 0; m_conf = 0; m_last = 0;
      end else begin
         if (gi) sb.push_back('{due: cyc + L, port: 1'b0});
         if (gl && lr && !lw) sb.push_back('{due: cyc + L, port: 1'b1});
         m_denied = (ifq && gl) ? ((m_denied < LIM) ? m_denied + 1 : LIM) : 0;
         if (ifq && lsq && m_conf < 65535) m_conf++;
         m_last = gi ? 1 : (gl ? 2 : 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   // Response monitor: pops the scoreboard whenever a response is due or presented.
   initial begin
      rsp_t e;
      bit has;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
               chk1("missed_rdvalid", 1'b0, 1'b1);
               void'(sb.pop_front());
            end
            has = (sb.size() > 0) && (sb[0].due == cyc);
            if (has) begin
               e = sb.pop_front();
               chk16("rdvalid_port", {14'd0, o_ls_rdvalid, o_if_rdvalid},
                     e.port ? 16'd2 : 16'd1);
               chk16("rddata", e.port ? o_ls_rddata : o_if_rddata, mem_word(cyc));
            end else begin
               chk16("spurious_rdvalid", {14'd0, o_ls_rdvalid, o_if_rdvalid}, 16'd0);
            end
         end
      end
   end

   initial begin
      bit ir, lr, lw, r;
      repeat (2) @(posedge clk);
      mon_en = 1'b1;
      // reset with requests present: waits follow raw requests, nothing granted
      step(1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, 16'h0);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h3333, 16'h4444);
      // lone fetch
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
      idle(L + 1);
      // simultaneous reads then fetch retries alone
      step(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0200, 16'h0);
      step(1'b0, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0);
      idle(L + 1);
      // continuous contention: fetch wins every fourth cycle
      for (int i = 0; i < 9; i++)
         step(1'b0, 1'b1, 16'h0040 + 16'(i), 1'b1, 1'b0, 16'h0400 + 16'(i), 16'h0);
      idle(L + 1);
      // store with rd and wr high versus fetch
      step(1'b0, 1'b1, 16'h0050, 1'b1, 1'b1, 16'h0300, 16'h1234);
      step(1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 16'h0, 16'h0);
      idle(L + 1);
      // back-to-back reads alternate ports
      step(1'b0, 1'b1, 16'h0060, 1'b0, 1'b0, 16'h0, 16'h0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0600, 16'h0);
      step(1'b0, 1'b1, 16'h0061, 1'b0, 1'b0, 16'h0, 16'h0);
      idle(L + 1);
      // reset while a read is in flight kills its response
      step(1'b0, 1'b1, 16'h0070, 1'b1, 1'b0, 16'h0700, 16'h0);
      step(1'b0, 1'b1, 16'h0070, 1'b0, 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      idle(L + 2);
      // random traffic with occasional reset
      for (int i = 0; i < 2000; i++) begin
         r  = ($urandom_range(0, 99) == 0);
         ir = ($urandom_range(0, 3) != 0);
         lr = ($urandom_range(0, 2) != 0);
         lw = ($urandom_range(0, 3) == 0);
         step(r, ir, 16'($urandom), lr, lw, 16'($urandom), 16'($urandom));
      end
      idle(L + 2);
      chk16("scoreboard_drained", 16'(sb.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
